// File: rtl/hit_buffer_if.sv
// hit_buffer_if: R18 input bundle, serialized hit stream and status for hit_buffer.
// The slave modport is the buffer itself; the master modport is the rasterizer /
// downstream environment that drives bundles and accepts hits.
interface hit_buffer_if #(
    parameter int SIGFIG  = 24,
    parameter int AXIS    = 3,
    parameter int COLORS  = 3,
    parameter int SAMPLES = 2,
    parameter int DEPTH   = 16
);
    localparam int LANE_W = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
    localparam int OCC_W  = $clog2(DEPTH) + 1;

    logic signed [SIGFIG-1:0] hit_R18S   [SAMPLES][AXIS];
    logic        [SIGFIG-1:0] color_R18U [COLORS];
    logic        [SAMPLES-1:0] hit_valid_R18H;

    logic signed [SIGFIG-1:0] zhit_S     [AXIS];
    logic        [SIGFIG-1:0] zcolor_U   [COLORS];
    logic        [LANE_W-1:0] zlane_U;
    logic                     zvalid_H;
    logic                     zready_H;

    logic                     halt_RnnnnL;
    logic        [OCC_W-1:0]  occupancy_U;
    logic                     overflow_err_H;

    modport master (
        output hit_R18S, color_R18U, hit_valid_R18H, zready_H,
        input  zhit_S, zcolor_U, zlane_U, zvalid_H,
        input  halt_RnnnnL, occupancy_U, overflow_err_H
    );

    modport slave (
        input  hit_R18S, color_R18U, hit_valid_R18H, zready_H,
        output zhit_S, zcolor_U, zlane_U, zvalid_H,
        output halt_RnnnnL, occupancy_U, overflow_err_H
    );
endinterface

// File: rtl/hit_buffer.sv
// hit_buffer: elastic FIFO of R18 sample-test bundles. Every bundle with at least
// one valid lane is stored whole; the head bundle is then drained one valid lane
// per cycle (ascending lane order) onto a ready/valid stream. A registered,
// active-low halt throttles the rasterizer early enough that SLACK in-flight
// bundles still fit; anything beyond that is dropped and flagged sticky.
module hit_buffer #(
    parameter int SIGFIG  = 24,
    parameter int RADIX   = 10,
    parameter int AXIS    = 3,
    parameter int COLORS  = 3,
    parameter int SAMPLES = 2,
    parameter int DEPTH   = 16,
    parameter int SLACK   = 8
) (
    input  logic          clk,
    input  logic          rst,
    hit_buffer_if.slave   bus
);
    localparam int LANE_W = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int OCC_W  = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL_LEVEL = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] HALT_LEVEL = OCC_W'(DEPTH - SLACK);

    // Parameter sanity: fraction bits must fit in the word, and the pointer
    // arithmetic relies on DEPTH being a power of two.
    if (RADIX >= SIGFIG || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 ||
        SLACK < 1 || SLACK >= DEPTH) begin : g_bad_params
        $error("hit_buffer: illegal parameter combination");
    end

    logic signed [SIGFIG-1:0]  hit_mem   [DEPTH][SAMPLES][AXIS];
    logic        [SIGFIG-1:0]  color_mem [DEPTH][COLORS];
    logic        [SAMPLES-1:0] mask_mem  [DEPTH];

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [OCC_W-1:0]   occupancy;
    logic [OCC_W-1:0]   occupancy_next;
    logic [SAMPLES-1:0] done;
    logic               halt_q;
    logic               overflow_q;

    logic [SAMPLES-1:0] remaining;
    logic [SAMPLES-1:0] lane_onehot;
    logic [LANE_W-1:0]  cur_lane;
    logic               lane_found;
    logic               push;
    logic               full;
    logic               xfer;
    logic               pop;
    logic               push_acc;

    assign push      = |bus.hit_valid_R18H;
    assign full      = (occupancy == FULL_LEVEL);
    assign remaining = mask_mem[rd_ptr] & ~done;
    assign xfer      = bus.zvalid_H & bus.zready_H;
    assign pop       = xfer & ((remaining & ~lane_onehot) == '0);
    assign push_acc  = push & (~full | pop);
    assign occupancy_next = occupancy + OCC_W'(push_acc) - OCC_W'(pop);

    // Pick the lowest-index lane of the head bundle not yet sent downstream.
    always_comb begin
        cur_lane    = '0;
        lane_onehot = '0;
        lane_found  = 1'b0;
        for (int s = 0; s < SAMPLES; s++) begin
            if (remaining[s] && !lane_found) begin
                lane_found     = 1'b1;
                cur_lane       = LANE_W'(s);
                lane_onehot[s] = 1'b1;
            end
        end
    end

    // Present the head bundle's current lane; data is don't-care when empty.
    always_comb begin
        for (int a = 0; a < AXIS; a++) begin
            bus.zhit_S[a] = hit_mem[rd_ptr][cur_lane][a];
        end
        for (int c = 0; c < COLORS; c++) begin
            bus.zcolor_U[c] = color_mem[rd_ptr][c];
        end
    end

    assign bus.zlane_U        = cur_lane;
    assign bus.zvalid_H       = (occupancy != '0);
    assign bus.occupancy_U    = occupancy;
    assign bus.halt_RnnnnL    = halt_q;
    assign bus.overflow_err_H = overflow_q;

    // Bundle storage: whole bundle (all lanes, mask, colour) written at the tail.
    always_ff @(posedge clk) begin
        if (push_acc && !rst) begin
            mask_mem[wr_ptr] <= bus.hit_valid_R18H;
            for (int s = 0; s < SAMPLES; s++) begin
                for (int a = 0; a < AXIS; a++) begin
                    hit_mem[wr_ptr][s][a] <= bus.hit_R18S[s][a];
                end
            end
            for (int c = 0; c < COLORS; c++) begin
                color_mem[wr_ptr][c] <= bus.color_R18U[c];
            end
        end
    end

    // Pointers, occupancy, per-head lane progress, halt and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occupancy  <= '0;
            done       <= '0;
            halt_q     <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                done   <= '0;
            end else if (xfer) begin
                done   <= done | lane_onehot;
            end
            occupancy  <= occupancy_next;
            halt_q     <= (occupancy_next < HALT_LEVEL);
            overflow_q <= overflow_q | (push & full & ~pop);
        end
    end
endmodule

// File: tb/tb_hit_buffer.sv
// tb_hit_buffer: directed-vector bench for hit_buffer with hand-computed
// expectations (DEPTH=16, SLACK=8, SAMPLES=2).
module tb_hit_buffer;
    logic clk = 1'b0;
    logic rst;
    int   check_count = 0;
    int   pass_count  = 0;

    hit_buffer_if #(.SIGFIG(24), .AXIS(3), .COLORS(3), .SAMPLES(2), .DEPTH(16)) bus ();

    hit_buffer #(
        .SIGFIG(24), .RADIX(10), .AXIS(3), .COLORS(3),
        .SAMPLES(2), .DEPTH(16), .SLACK(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Count a comparison and report it when observed and expected differ.
    task automatic checkOutput(input string tag, input int got, input int exp);
        check_count++;
        if (got === exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Drive one R18 bundle onto the input side.
    task automatic applyStimulus(input logic [1:0] mask,
                                 input int x0, input int y0, input int z0,
                                 input int x1, input int y1, input int z1,
                                 input int r, input int g, input int b);
        bus.hit_valid_R18H = mask;
        bus.hit_R18S[0][0] = 24'(x0);
        bus.hit_R18S[0][1] = 24'(y0);
        bus.hit_R18S[0][2] = 24'(z0);
        bus.hit_R18S[1][0] = 24'(x1);
        bus.hit_R18S[1][1] = 24'(y1);
        bus.hit_R18S[1][2] = 24'(z1);
        bus.color_R18U[0]  = 24'(r);
        bus.color_R18U[1]  = 24'(g);
        bus.color_R18U[2]  = 24'(b);
    endtask

    task automatic idle();
        bus.hit_valid_R18H = 2'b00;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkStatus(input string tag, input int valid, input int occ,
                               input int halt, input int ovf);
        checkOutput({tag, ".zvalid"}, int'(bus.zvalid_H), valid);
        checkOutput({tag, ".occ"},    int'(bus.occupancy_U), occ);
        checkOutput({tag, ".halt"},   int'(bus.halt_RnnnnL), halt);
        checkOutput({tag, ".ovf"},    int'(bus.overflow_err_H), ovf);
    endtask

    task automatic checkHit(input string tag, input int lane,
                            input int x, input int y, input int z);
        checkOutput({tag, ".zvalid"}, int'(bus.zvalid_H), 1);
        checkOutput({tag, ".lane"},   int'(bus.zlane_U), lane);
        checkOutput({tag, ".x"},      int'(bus.zhit_S[0]), x);
        checkOutput({tag, ".y"},      int'(bus.zhit_S[1]), y);
        checkOutput({tag, ".z"},      int'(bus.zhit_S[2]), z);
    endtask

    initial begin
        rst = 1'b1;
        bus.zready_H = 1'b0;
        idle();

        // Reset held for 3 cycles with random inputs.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'($urandom), int'($urandom), int'($urandom), int'($urandom),
                          int'($urandom), int'($urandom), int'($urandom),
                          int'($urandom), int'($urandom), int'($urandom));
            bus.zready_H = 1'($urandom);
            tick();
            checkStatus("reset", 0, 0, 1, 0);
        end
        rst = 1'b0;
        idle();
        bus.zready_H = 1'b0;
        tick();
        checkStatus("post_reset", 0, 0, 1, 0);

        // Single full bundle, drained back to back.
        bus.zready_H = 1'b1;
        applyStimulus(2'b11, 5, 7, 100, 6, 7, 90, 255, 0, 0);
        tick();
        idle();
        checkHit("single_l0", 0, 5, 7, 100);
        checkOutput("single_l0.r", int'(bus.zcolor_U[0]), 255);
        checkOutput("single_l0.g", int'(bus.zcolor_U[1]), 0);
        tick();
        checkHit("single_l1", 1, 6, 7, 90);
        checkOutput("single_l1.r", int'(bus.zcolor_U[0]), 255);
        tick();
        checkStatus("single_end", 0, 0, 1, 0);

        // Sparse masks: 00 is never stored, 10 then 01 queue up.
        bus.zready_H = 1'b0;
        applyStimulus(2'b00, 1, 1, 1, 1, 1, 1, 1, 1, 1);
        tick();
        checkOutput("sparse_00.occ", int'(bus.occupancy_U), 0);
        applyStimulus(2'b10, 0, 0, 0, 11, 12, 13, 1, 2, 3);
        tick();
        checkOutput("sparse_10.occ", int'(bus.occupancy_U), 1);
        applyStimulus(2'b01, 21, 22, 23, 0, 0, 0, 4, 5, 6);
        tick();
        checkOutput("sparse_01.occ", int'(bus.occupancy_U), 2);
        idle();
        tick();
        checkHit("sparse_stall", 1, 11, 12, 13);
        checkOutput("sparse_stall.occ", int'(bus.occupancy_U), 2);
        bus.zready_H = 1'b1;
        tick();
        checkHit("sparse_b2", 0, 21, 22, 23);
        checkOutput("sparse_b2.g", int'(bus.zcolor_U[1]), 5);
        checkOutput("sparse_b2.occ", int'(bus.occupancy_U), 1);
        tick();
        checkStatus("sparse_end", 0, 0, 1, 0);

        // Halt threshold: 8 stalled pushes drive halt low at the 8th push edge.
        bus.zready_H = 1'b0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(2'b01, i, 0, 0, 0, 0, 0, 0, 0, 0);
            tick();
            checkOutput("halt_fill.halt", int'(bus.halt_RnnnnL), (i < 7) ? 1 : 0);
        end
        idle();
        checkOutput("halt_fill.occ", int'(bus.occupancy_U), 8);
        checkOutput("halt_head.x", int'(bus.zhit_S[0]), 0);
        bus.zready_H = 1'b1;
        tick();
        checkOutput("halt_release.occ", int'(bus.occupancy_U), 7);
        checkOutput("halt_release.halt", int'(bus.halt_RnnnnL), 1);
        for (int j = 1; j < 8; j++) begin
            checkOutput("halt_drain.x", int'(bus.zhit_S[0]), j);
            tick();
        end
        checkStatus("halt_end", 0, 0, 1, 0);

        // Overflow: fill to 16, drop a 17th, then push alongside a pop while full.
        bus.zready_H = 1'b0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(2'b01, 100 + i, 0, 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
        checkStatus("full", 1, 16, 0, 0);
        applyStimulus(2'b01, 999, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkStatus("drop", 1, 16, 0, 1);
        bus.zready_H = 1'b1;
        applyStimulus(2'b01, 200, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        idle();
        checkStatus("push_pop_full", 1, 16, 0, 1);
        for (int j = 0; j < 16; j++) begin
            checkOutput("ovf_drain.x", int'(bus.zhit_S[0]), (j < 15) ? 101 + j : 200);
            tick();
        end
        checkStatus("ovf_end", 0, 0, 1, 1);

        // Reset mid-operation with a push on the reset cycle.
        bus.zready_H = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(2'b01, 300 + i, 0, 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
        checkOutput("mid.occ", int'(bus.occupancy_U), 5);
        rst = 1'b1;
        applyStimulus(2'b01, 777, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        idle();
        checkStatus("mid_reset", 0, 0, 1, 0);
        applyStimulus(2'b11, 400, 1, 2, 401, 3, -4, 9, 8, 7);
        tick();
        idle();
        checkHit("mid_after_l0", 0, 400, 1, 2);
        checkOutput("mid_after.occ", int'(bus.occupancy_U), 1);
        checkOutput("mid_after.g", int'(bus.zcolor_U[1]), 8);
        bus.zready_H = 1'b1;
        tick();
        checkHit("mid_after_l1", 1, 401, 3, -4);
        tick();
        checkStatus("mid_end", 0, 0, 1, 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule

// File: doc/hit_buffer.md
# hit_buffer

Elastic buffer between the rasterizer's sample-test output (R18) and the downstream depth-test / frame-buffer write unit. It captures every R18 bundle that carries at least one valid hit and serializes the valid samples to a one-hit-per-cycle ready/valid stream. It also generates the active-low `halt_RnnnnL` back-pressure signal that stalls the rasterizer front end before the buffer can overflow.

## Interface
- `SIGFIG`, 24: bits in position and colour words.
- `RADIX`, 10: fraction bits; the block only passes this through.
- `AXIS`, 3: axes per hit (x, y, z).
- `COLORS`, 3: colour channels.
- `SAMPLES`, 2: samples tested per cycle, i.e. lanes per R18 bundle.
- `DEPTH`, 16: bundle entries in the buffer. Must be a power of 2 and ≥ 4.
- `SLACK`, 8: bundles that may still arrive after halt is asserted (rasterizer pipe depth). Must satisfy 1 ≤ SLACK < DEPTH.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset. Synchronous, active-high.
- `hit_R18S`  in  signed [SIGFIG-1:0] [SAMPLES][AXIS]  per-lane hit location and depth.
- `color_R18U`  in  unsigned [SIGFIG-1:0] [COLORS]  triangle colour, shared by all lanes.
- `hit_valid_R18H`  in  1 [SAMPLES]  per-lane hit flag.
- `zhit_S`  out  signed [SIGFIG-1:0] [AXIS]  serialized hit.
- `zcolor_U`  out  unsigned [SIGFIG-1:0] [COLORS]  colour of the current hit.
- `zlane_U`  out  $clog2(SAMPLES) (min 1)  lane index of the current hit.
- `zvalid_H`  out  1  output data valid.
- `zready_H`  in  1  downstream accepts.
- `halt_RnnnnL`  out  1  0 = rasterizer must stall.
- `occupancy_U`  out  $clog2(DEPTH)+1  bundles currently stored.
- `overflow_err_H`  out  1  sticky flag; set when a bundle is dropped.

## Operation
- **Push:** a push occurs on any cycle in which OR(`hit_valid_R18H`) = 1.
  - The bundle is written to the tail: all lanes, the valid mask and the colour.
  - A bundle whose mask is all-zero is never stored.
  - The input has no ready signal; the upstream side is controlled only through halt.
- **Head lane selection:** the head entry keeps a `done` mask register.
  - remaining = head_mask & ~done.
  - The current lane is the lowest-index set bit of remaining.
- **Output:**
  - `zvalid_H` = (occupancy ≠ 0).
  - `zhit_S`, `zcolor_U` and `zlane_U` are driven from the head entry at the current lane. This path is combinational from the storage and `done` registers.
- **Transfer:** a transfer happens when `zvalid_H` & `zready_H`.
  - On a transfer, the current lane's bit is set in `done`.
  - If that was the last remaining bit, the head is popped and `done` clears to 0.
- **Ordering:** bundles leave in arrival order; lanes within a bundle leave in ascending index order.
- **Full buffer:**
  - A push while occupancy = DEPTH and no pop occurs that cycle drops the bundle. `overflow_err_H` is set and stays 1 until `rst`. Stored data is untouched.
  - A push and a pop in the same cycle while full are both accepted; occupancy stays at DEPTH.
- **Occupancy:** occupancy_next = occupancy + push_accepted − pop.
  - Pointers wrap modulo DEPTH.
  - Occupancy never exceeds DEPTH and never goes below 0.
- **Halt:** `halt_RnnnnL` is registered: `halt_RnnnnL` ← (occupancy_next < DEPTH − SLACK).
- **Reset values:** `zvalid_H`=0, `occupancy_U`=0, `halt_RnnnnL`=1, `overflow_err_H`=0, `done`=0, pointers=0. Data outputs are don't-care while `zvalid_H`=0.
- **Reset mid-operation:** all stored bundles are discarded, and a push on the reset cycle is ignored.

## Timing
- Latency from R18 to output is 1 cycle. A bundle pushed at edge N into an empty buffer gives `zvalid_H`=1 during the cycle after edge N.
- Throughput is one hit per cycle while `zready_H`=1. A bundle with k valid lanes takes exactly k transfer cycles.
- There are no bubbles between bundles: the next bundle's first lane is presented in the cycle after the previous bundle's last transfer.
- `halt_RnnnnL` changes one edge after the push or pop that crosses the threshold. It asserts (0) when occupancy reaches DEPTH − SLACK and deasserts once occupancy is back below that value.
- `overflow_err_H` rises at the edge of the dropped push.
- `zready_H` may toggle freely. Outputs remain stable while `zvalid_H`=1 and `zready_H`=0.

## Test plan
- **Reset values:** hold `rst` for 3 cycles with random inputs → `zvalid_H`=0, `halt_RnnnnL`=1, `occupancy_U`=0, `overflow_err_H`=0 on every cycle.
- **Single full bundle:** push one bundle, mask 2'b11, hits (5,7,100) and (6,7,90), colour (255,0,0), `zready_H`=1 → two consecutive beats: lane 0 (5,7,100), then lane 1 (6,7,90), both with colour (255,0,0). Then `zvalid_H`=0.
- **Sparse masks:** push masks 2'b00, 2'b10, 2'b01 on consecutive cycles → the 00 bundle is never stored and `occupancy_U` peaks at 2. The output is lane 1 of bundle 1, then lane 0 of bundle 2.
- **Halt threshold (DEPTH=16, SLACK=8):** hold `zready_H`=0 and push 8 bundles → `halt_RnnnnL`=0 from the edge after the 8th push. Raise `zready_H` → `halt_RnnnnL`=1 one edge after occupancy drops to 7.
- **Overflow and full-buffer concurrency:** fill to 16 and push a 17th with no pop → `overflow_err_H`=1 and the 17th bundle is absent from the output. Refill to 16 and push on the same cycle as the last-lane transfer of the head → occupancy stays 16 and the pushed bundle is output in order.
- **Reset mid-operation:** assert `rst` with occupancy = 5 and a push on the same cycle → next cycle `occupancy_U`=0, `zvalid_H`=0, `overflow_err_H`=0. The first post-reset bundle appears with 1-cycle latency.
